vfpu_operand_feeder: RTL and testbench

Upstream stage of the vector FPU datapath. Accepts two independent operand streams (A and B) over valid/ready handshakes, buffers each in a small FIFO, and pairs them in arrival order. It presents each pair to the VFPU's `operandA`/`operandB`/`operands_valid` inputs and holds it there until the VFPU signals ready. A job-length counter bounds every job and raises a one-cycle `done_o` once the last pair has been issued.

---
 rtl/vfpu_operand_feeder.sv | 229 ++++++++++++++++++++++
 tb/tb_vfpu_operand_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : vfpu_operand_feeder
//  Purpose  : Buffers two independent operand streams, pairs them in arrival
//             order and presents each pair to the vector FPU, bounded by a
//             per-job length counter with a one-cycle completion pulse.
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  vfpu_operand_fifo : first-word fall-through FIFO with reset storage.
//  The full/empty flags are decoded from the occupancy register only, so they
//  never depend combinationally on the same-cycle push or pop.
// ----------------------------------------------------------------------------
module vfpu_operand_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (occ == '0);
  assign full  = (occ == OCC_W'(FIFO_DEPTH));

endmodule

// ----------------------------------------------------------------------------
//  vfpu_operand_feeder : top level.
// ----------------------------------------------------------------------------
module vfpu_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  output logic [DATA_WIDTH-1:0] operandA_o,
  output logic [DATA_WIDTH-1:0] operandB_o,
  output logic                  operands_valid_o,
  input  logic                  vfpu_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  issued_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [CNT_WIDTH-1:0] job_len;
  logic [CNT_WIDTH-1:0] acc_a_cnt;
  logic [CNT_WIDTH-1:0] acc_b_cnt;
  logic [CNT_WIDTH-1:0] issued_cnt;

  logic                 running;
  logic                 start_accept;
  logic                 a_push;
  logic                 b_push;
  logic                 issue;
  logic                 last_issue;

  logic                 a_empty;
  logic                 a_full;
  logic                 b_empty;
  logic                 b_full;
  logic [DATA_WIDTH-1:0] a_head;
  logic [DATA_WIDTH-1:0] b_head;

  assign running      = (state == ST_RUN);
  assign start_accept = (state == ST_IDLE) && start_i;

  // Acceptance is capped at the job length so both FIFOs drain completely by job end.
  assign a_ready_o = running && !a_full && (acc_a_cnt < job_len);
  assign b_ready_o = running && !b_full && (acc_b_cnt < job_len);
  assign a_push    = a_valid_i && a_ready_o;
  assign b_push    = b_valid_i && b_ready_o;

  assign operands_valid_o = running && !a_empty && !b_empty;
  assign issue            = operands_valid_o && vfpu_ready_i;
  assign last_issue       = issue && ((issued_cnt + 1'b1) == job_len);

  assign operandA_o   = a_head;
  assign operandB_o   = b_head;
  assign busy_o       = running;
  assign done_o       = (state == ST_DONE);
  assign issued_cnt_o = issued_cnt;

  vfpu_operand_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (a_push),
    .push_data (a_data_i),
    .pop       (issue),
    .head      (a_head),
    .empty     (a_empty),
    .full      (a_full)
  );

  vfpu_operand_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (b_push),
    .push_data (b_data_i),
    .pop       (issue),
    .head      (b_head),
    .empty     (b_empty),
    .full      (b_full)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: a zero-length job goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_next = (len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_issue) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Job length latch and acceptance/issue counters; cleared by an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job_len    <= '0;
      acc_a_cnt  <= '0;
      acc_b_cnt  <= '0;
      issued_cnt <= '0;
    end else if (start_accept) begin
      job_len    <= len_i;
      acc_a_cnt  <= '0;
      acc_b_cnt  <= '0;
      issued_cnt <= '0;
    end else begin
      if (a_push) begin
        acc_a_cnt <= acc_a_cnt + 1'b1;
      end
      if (b_push) begin
        acc_b_cnt <= acc_b_cnt + 1'b1;
      end
      if (issue) begin
        issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vfpu_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vfpu_operand_feeder
//  Purpose  : Self-checking bench for vfpu_operand_feeder using a queue-based
//             reference model of the job, the two buffers and the pairing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vfpu_operand_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] len_i = '0;
  logic [DW-1:0] a_data_i = '0;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [DW-1:0] b_data_i = '0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [DW-1:0] operandA_o;
  logic [DW-1:0] operandB_o;
  logic          operands_valid_o;
  logic          vfpu_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] issued_cnt_o;

  vfpu_operand_feeder #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .len_i            (len_i),
    .a_data_i         (a_data_i),
    .a_valid_i        (a_valid_i),
    .a_ready_o        (a_ready_o),
    .b_data_i         (b_data_i),
    .b_valid_i        (b_valid_i),
    .b_ready_o        (b_ready_o),
    .operandA_o       (operandA_o),
    .operandB_o       (operandB_o),
    .operands_valid_o (operands_valid_o),
    .vfpu_ready_i     (vfpu_ready_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .issued_cnt_o     (issued_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: job phase, buffered words and counts.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_len = 0;
  int            m_acc_a = 0;
  int            m_acc_b = 0;
  int            m_issued = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  // Words offered by the two sources for the current job.
  logic [DW-1:0] src_a[$];
  logic [DW-1:0] src_b[$];
  int            done_pulses = 0;

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_len = 0;
    m_acc_a = 0; m_acc_b = 0; m_issued = 0;
    qa.delete(); qb.delete();
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input logic st, input int ln,
                      input logic av, input logic [DW-1:0] ad,
                      input logic bv, input logic [DW-1:0] bd,
                      input logic vr,
                      output logic took_a, output logic took_b);
    logic e_ar, e_br, e_val, iss;
    start_i = st; len_i = CW'(ln);
    a_valid_i = av; a_data_i = ad;
    b_valid_i = bv; b_data_i = bd;
    vfpu_ready_i = vr;
    @(negedge clk_i);
    e_ar  = m_busy && (qa.size() < DEPTH) && (m_acc_a < m_len);
    e_br  = m_busy && (qb.size() < DEPTH) && (m_acc_b < m_len);
    e_val = m_busy && (qa.size() > 0) && (qb.size() > 0);
    vectors++;
    if ({busy_o, done_o} !== {m_busy, m_done}) begin
      miscompares++;
      $display("FAIL busy_done t=%0t got %b%b want %b%b", $time, busy_o, done_o, m_busy, m_done);
    end
    vectors++;
    if ({a_ready_o, b_ready_o} !== {e_ar, e_br}) begin
      miscompares++;
      $display("FAIL readies t=%0t got %b%b want %b%b", $time, a_ready_o, b_ready_o, e_ar, e_br);
    end
    vectors++;
    if (operands_valid_o !== e_val) begin
      miscompares++;
      $display("FAIL operands_valid t=%0t got %b want %b", $time, operands_valid_o, e_val);
    end
    vectors++;
    if (issued_cnt_o !== CW'(m_issued)) begin
      miscompares++;
      $display("FAIL issued_cnt t=%0t got %0d want %0d", $time, issued_cnt_o, m_issued);
    end
    if (e_val) begin
      vectors++;
      if ({operandA_o, operandB_o} !== {qa[0], qb[0]}) begin
        miscompares++;
        $display("FAIL operands t=%0t got %h/%h want %h/%h", $time, operandA_o, operandB_o, qa[0], qb[0]);
      end
    end
    if (done_o === 1'b1) done_pulses++;
    // Advance the reference model by one cycle.
    iss    = e_val && vr;
    took_a = e_ar && av;
    took_b = e_br && bv;
    if (iss) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
      m_issued++;
    end
    if (took_a) begin qa.push_back(ad); m_acc_a++; end
    if (took_b) begin qb.push_back(bd); m_acc_b++; end
    if (!m_busy && !m_done && st) begin
      m_len = ln; m_acc_a = 0; m_acc_b = 0; m_issued = 0;
      m_busy = (ln != 0);
      m_done = (ln == 0);
    end else if (m_busy && iss && m_issued == m_len) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Runs one job from src_a/src_b. Sources start after a delay and then offer
  // with the given percentage; the VFPU is held off for vr_low cycles.
  task automatic run_job(input int len, input int a_delay, input int b_delay,
                         input int a_pct, input int b_pct, input int vr_pct,
                         input int vr_low, input int stop_after);
    int ia = 0, ib = 0, c = 1;
    logic av, bv, vr, ta, tb;
    step(1'b1, len, 1'b0, '0, 1'b0, '0, 1'b0, ta, tb);
    while ((m_busy || m_done) && c < 400) begin
      if (stop_after > 0 && m_issued >= stop_after) break;
      av = (c > a_delay) && (ia < src_a.size()) && ($urandom_range(99, 0) < a_pct);
      bv = (c > b_delay) && (ib < src_b.size()) && ($urandom_range(99, 0) < b_pct);
      vr = (c > vr_low) && ($urandom_range(99, 0) < vr_pct);
      step(1'b0, 0, av, av ? src_a[ia] : DW'($urandom), bv, bv ? src_b[ib] : DW'($urandom), vr, ta, tb);
      if (ta) ia++;
      if (tb) ib++;
      c++;
    end
    vectors++;
    if (c >= 400) begin
      miscompares++;
      $display("FAIL job_bound len=%0d got %0d cycles want <400", len, c);
    end
  endtask

  task automatic fill_sources(input int n);
    src_a.delete(); src_b.delete();
    for (int i = 0; i < n; i++) begin
      src_a.push_back(DW'($urandom));
      src_b.push_back(DW'($urandom));
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    vectors++;
    if ({a_ready_o, b_ready_o, operands_valid_o, busy_o, done_o, operandA_o, operandB_o, issued_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b%b val=%b busy=%b done=%b A=%h B=%h cnt=%0d want all 0",
               a_ready_o, b_ready_o, operands_valid_o, busy_o, done_o, operandA_o, operandB_o, issued_cnt_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_streaming();
    logic ta, tb;
    src_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    src_b = '{32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000};
    done_pulses = 0;
    // Cycle 0: start; cycles 1-4: words; cycles 2-5 issue; cycle 6 done.
    step(1'b1, 4, 1'b0, '0, 1'b0, '0, 1'b1, ta, tb);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 1'b1, src_a[i], 1'b1, src_b[i], 1'b1, ta, tb);
    end
    step(1'b0, 0, 1'b0, '0, 1'b0, '0, 1'b1, ta, tb);
    vectors++;
    if (done_o !== 1'b1 || issued_cnt_o !== 16'd4) begin
      miscompares++;
      $display("FAIL stream_done_cycle6 got done=%b cnt=%0d want done=1 cnt=4", done_o, issued_cnt_o);
    end
    step(1'b0, 0, 1'b0, '0, 1'b0, '0, 1'b1, ta, tb);
    step(1'b0, 0, 1'b0, '0, 1'b0, '0, 1'b1, ta, tb);
    vectors++;
    if (done_pulses != 1) begin
      miscompares++;
      $display("FAIL stream_done_pulses got %0d want 1", done_pulses);
    end
  endtask

  task automatic test_b_lags();
    fill_sources(6);
    run_job(6, 0, 5, 100, 100, 100, 0, 0);
    vectors++;
    if (issued_cnt_o !== 16'd6) begin
      miscompares++;
      $display("FAIL b_lags_count got %0d want 6", issued_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    fill_sources(3);
    run_job(3, 0, 0, 100, 100, 100, 6, 0);
    vectors++;
    if (issued_cnt_o !== 16'd3) begin
      miscompares++;
      $display("FAIL backpressure_count got %0d want 3", issued_cnt_o);
    end
  endtask

  task automatic test_zero_len();
    fill_sources(2);
    done_pulses = 0;
    run_job(0, 0, 0, 100, 100, 100, 0, 0);
    vectors++;
    if (done_pulses != 1 || issued_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_len got pulses=%0d cnt=%0d want pulses=1 cnt=0", done_pulses, issued_cnt_o);
    end
  endtask

  task automatic test_bounded();
    fill_sources(5);
    run_job(2, 0, 0, 100, 100, 100, 0, 0);
    vectors++;
    if (m_acc_a != 2 || m_acc_b != 2 || issued_cnt_o !== 16'd2) begin
      miscompares++;
      $display("FAIL bounded got accA=%0d accB=%0d cnt=%0d want 2/2/2", m_acc_a, m_acc_b, issued_cnt_o);
    end
  endtask

  task automatic test_reset_mid_job();
    fill_sources(8);
    run_job(8, 0, 0, 100, 100, 100, 0, 3);
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({a_ready_o, b_ready_o, operands_valid_o, busy_o, done_o, operandA_o, operandB_o, issued_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_job_reset got rdy=%b%b val=%b busy=%b done=%b cnt=%0d want all 0",
               a_ready_o, b_ready_o, operands_valid_o, busy_o, done_o, issued_cnt_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    fill_sources(2);
    run_job(2, 0, 0, 100, 100, 100, 0, 0);
    vectors++;
    if (issued_cnt_o !== 16'd2) begin
      miscompares++;
      $display("FAIL after_reset_job got %0d want 2", issued_cnt_o);
    end
  endtask

  task automatic test_random();
    int len;
    for (int j = 0; j < 12; j++) begin
      len = $urandom_range(12, 1);
      fill_sources(len + $urandom_range(3, 0));
      run_job(len, $urandom_range(4, 0), $urandom_range(4, 0),
              $urandom_range(100, 30), $urandom_range(100, 30),
              $urandom_range(100, 30), $urandom_range(3, 0), 0);
      vectors++;
      if (issued_cnt_o !== CW'(len)) begin
        miscompares++;
        $display("FAIL random_job%0d_count got %0d want %0d", j, issued_cnt_o, len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_b_lags();
    test_backpressure();
    test_zero_len();
    test_bounded();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
